base_credit_tx: RTL and testbench
=================================

# base_credit_tx

Credit-based transmitter that accepts words on a valid/ready upstream interface and drives them to a remote receive FIFO over a valid-only downstream link. Downstream has no ready; flow control is a credit count initialised to the remote FIFO depth. The count drops by one per word sent and rises by one per credit-return pulse from the remote read side. Sits at the write end of any long-haul or pipelined path whose sink is a fixed-depth `base_fifo`-style buffer.

## Interface
- `width`, 1, data word width
- `LOG_CREDITS`, 4, log2 of remote FIFO depth
- `CREDITS`, 2**LOG_CREDITS, initial and maximum credit count (must equal remote depth)
- `clk`  input  1  clock, all state on rising edge
- `reset`  input  1  asynchronous, active-low reset (asserted when 0)
- `i_v`  input  1  upstream word valid
- `i_d`  input  width  upstream word
- `i_r`  output  1  upstream ready; transfer when `i_v & i_r`
- `o_v`  output  1  downstream word strobe, one cycle per word
- `o_d`  output  width  downstream word, valid when `o_v`=1
- `cr_v`  input  1  credit return, one pulse per remote entry freed, at most one per cycle
- `o_credits`  output  LOG_CREDITS+1  current credit count
- `o_idle`  output  1  `o_credits == CREDITS` (all remote entries free)
- `o_err`  output  1  sticky credit-overflow error

## Operation
- Reset values: credit count = CREDITS, `o_v`=0, `o_d`=0, `o_err`=0. Consequently `i_r`=1 and `o_idle`=1 while `reset`=0.
- `i_r` = (count != 0). It is driven from the count register only, with no combinational path from `i_v` or `cr_v`.
- send = `i_v & i_r`.
- `o_v` register <= send.
- `o_d` register <= `i_d` when send; otherwise it holds its value. Downstream ignores `o_d` when `o_v`=0.
- Count update:
  - send only: count−1.
  - `cr_v` only: count+1.
  - Both in the same cycle: count unchanged.
  - Neither: count unchanged.
- Overflow: `cr_v`=1 with count == CREDITS and no send.
  - Count saturates at CREDITS.
  - `o_err` sets and stays set until reset.
- Underflow cannot occur, because send requires count != 0.
- Count arithmetic is LOG_CREDITS+1 bits, unsigned, with no wrap. The range 0..CREDITS is legal.
- No state machine beyond the counter. Two states are implied:
  - SEND: count > 0.
  - STALL: count == 0. Exit on `cr_v`.
- Reset mid-traffic: all state returns to reset values immediately, with no end-of-frame drain. The remote FIFO must be reset in the same domain event.

## Timing
- Latency `i_d` -> `o_d`: 1 cycle. A word accepted on edge N is presented with `o_v`=1 in cycle N+1.
- Throughput: one word per cycle while count > 0.
- Credit loop:
  - `cr_v` sampled at edge N raises count at N+1.
  - If that takes count from 0 to 1, `i_r` rises in cycle N+1 and a send can occur at edge N+1.
- With count == 1:
  - A send alone at edge N drops `i_r` in cycle N+1.
  - Send plus `cr_v` at edge N keeps `i_r`=1.
- `o_credits`, `o_idle`, `o_err` are all registered or direct decodes of registers. They reflect edge N in cycle N+1.
- The reset deassertion edge is not synchronised here; the parent provides a synchronised release.

## Structure
- No shared package needed.
- The counter width function LOG_CREDITS+1 lives as a localparam.
- One natural sub-module is `base_credit_cnt`: saturating up/down counter with parameterised init value, `inc`/`dec` inputs, `zero`/`full` decodes and a sticky overflow flag. It uses the same asynchronous active-low reset.
- Data and strobe registers are plain flops in the top module.

## Test plan
- Reset release, LOG_CREDITS=2 -> `o_credits`=4, `i_r`=1, `o_idle`=1, `o_v`=0, `o_err`=0.
- `i_v`=1 for 6 cycles with data 0x1..0x6, `cr_v`=0 ->
  - `o_v` pulses 4 cycles carrying 0x1..0x4, each one cycle after acceptance.
  - `i_r`=0 from cycle 5.
  - `o_credits`=0.
- From count 0, a single `cr_v` pulse at edge N -> `i_r`=1 in N+1; 0x5 accepted at N+1 and appears on `o_d` at N+2; count returns to 0.
- Count 1, `i_v`=1 and `cr_v`=1 together for 10 cycles -> 10 consecutive words out, count stays 1, `i_r` never drops.
- Count 4 (idle), `cr_v`=1 with `i_v`=0 -> count stays 4, `o_err`=1 next cycle and remains 1 through further traffic.
- Assert `reset`=0 mid-burst with count 2 and `o_v`=1 -> `o_v`=0 and `o_credits`=4 immediately (asynchronous); after release, normal sending resumes.

Source files
------------

// File: rtl/base_credit_tx_pkg.sv
// Shared defaults and sizing helpers for the credit transmitter.
package base_credit_tx_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_LOG_CREDITS = 4;

  // Credit counter must hold 0..2**log_credits inclusive.
  function automatic int unsigned cnt_width(input int unsigned log_credits);
    return log_credits + 32'd1;
  endfunction

endpackage

// File: rtl/base_credit_tx_if.sv
// Upstream valid/ready, downstream strobe, credit return and status.
interface base_credit_tx_if
  import base_credit_tx_pkg::*;
#(
  parameter int unsigned width       = DEF_WIDTH,
  parameter int unsigned LOG_CREDITS = DEF_LOG_CREDITS
);

  logic                   i_v;
  logic [width-1:0]       i_d;
  logic                   i_r;
  logic                   o_v;
  logic [width-1:0]       o_d;
  logic                   cr_v;
  logic [LOG_CREDITS:0]   o_credits;
  logic                   o_idle;
  logic                   o_err;

  // Transmitter side.
  modport slave (
    input  i_v, i_d, cr_v,
    output i_r, o_v, o_d, o_credits, o_idle, o_err
  );

  // Producer / remote-receiver side.
  modport master (
    output i_v, i_d, cr_v,
    input  i_r, o_v, o_d, o_credits, o_idle, o_err
  );

endinterface

// File: rtl/base_credit_cnt.sv
// Saturating up/down credit counter with registered zero/full decodes
// and a sticky overflow flag.
module base_credit_cnt #(
  parameter int unsigned W    = 5,
  parameter int unsigned INIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         full,
  output logic         ovf
);

  logic [W-1:0] count_n;
  logic         ovf_c;

  // Next count; inc at the ceiling saturates and flags overflow.
  always_comb begin
    count_n = count;
    ovf_c   = 1'b0;
    if (inc && !dec) begin
      if (count == W'(INIT)) begin
        ovf_c = 1'b1;
      end else begin
        count_n = count + W'(1);
      end
    end else if (dec && !inc && !zero) begin
      count_n = count - W'(1);
    end
  end

  // Count, decodes and sticky error; decodes are registered from count_n.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= W'(INIT);
      zero  <= (INIT == 32'd0);
      full  <= 1'b1;
      ovf   <= 1'b0;
    end else begin
      count <= count_n;
      zero  <= (count_n == W'(0));
      full  <= (count_n == W'(INIT));
      if (ovf_c) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/base_credit_tx.sv
// Credit-based transmitter: valid/ready in, valid-only out, credits
// track free entries in the remote fixed-depth FIFO.
module base_credit_tx
  import base_credit_tx_pkg::*;
#(
  parameter int unsigned width       = DEF_WIDTH,
  parameter int unsigned LOG_CREDITS = DEF_LOG_CREDITS
) (
  input  logic             clk,
  input  logic             reset,
  base_credit_tx_if.slave  bus
);

  localparam int unsigned CNT_W   = cnt_width(LOG_CREDITS);
  localparam int unsigned CREDITS = 32'd1 << LOG_CREDITS;

  logic             send_c;
  logic [CNT_W-1:0] count;
  logic             zero;
  logic             full;
  logic             ovf;

  // Ready depends only on the credit register, never on i_v or cr_v.
  assign bus.i_r = ~zero;
  assign send_c  = bus.i_v & ~zero;

  base_credit_cnt #(
    .W    (CNT_W),
    .INIT (CREDITS)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.cr_v),
    .dec   (send_c),
    .count (count),
    .zero  (zero),
    .full  (full),
    .ovf   (ovf)
  );

  assign bus.o_credits = count;
  assign bus.o_idle    = full;
  assign bus.o_err     = ovf;

  // Downstream strobe and data; data holds when nothing is sent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.o_v <= 1'b0;
      bus.o_d <= width'(0);
    end else begin
      bus.o_v <= send_c;
      if (send_c) begin
        bus.o_d <= bus.i_d;
      end
    end
  end

endmodule

// File: tb/tb_base_credit_tx.sv
// Randomized and directed bench for base_credit_tx with a credit model.
module tb_base_credit_tx;

  localparam int W  = 8;
  localparam int LC = 2;
  localparam int CR = 4;

  typedef logic [W+LC+4:0] vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  int         m_cnt;
  bit         m_err;
  bit         m_ov;
  logic [W-1:0] m_od;

  base_credit_tx_if #(.width(W), .LOG_CREDITS(LC)) bus();

  base_credit_tx #(.width(W), .LOG_CREDITS(LC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    m_cnt = CR;
    m_err = 1'b0;
    m_ov  = 1'b0;
    m_od  = '0;
  endfunction

  function automatic vec_t obs();
    return {bus.o_v, bus.o_d, bus.o_credits, bus.i_r, bus.o_idle, bus.o_err};
  endfunction

  function automatic vec_t expv();
    logic [LC:0] c;
    c = (LC+1)'(m_cnt);
    return {m_ov, m_od, c, (m_cnt != 0), (m_cnt == CR), m_err};
  endfunction

  // Drive one cycle of inputs, clock it, advance the model.
  task automatic step(input bit v, input logic [W-1:0] d, input bit cr);
    bit acc;
    bus.i_v  = v;
    bus.i_d  = d;
    bus.cr_v = cr;
    acc = v && (m_cnt != 0);
    @(posedge clk);
    #1;
    if (acc && !cr) m_cnt = m_cnt - 1;
    else if (cr && !acc) begin
      if (m_cnt == CR) m_err = 1'b1;
      else m_cnt = m_cnt + 1;
    end
    m_ov = acc;
    if (acc) m_od = d;
    bus.i_v  = 1'b0;
    bus.cr_v = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_v = 1'b0; bus.i_d = '0; bus.cr_v = 1'b0;
    reset = 1'b0;
    model_reset();
    #12;
    tests++;
    if (obs() !== expv()) begin
      fails++;
      $display("FAIL reset_state: got %h want %h", obs(), expv());
    end
    tests++;
    if (bus.o_credits !== 3'd4) begin
      fails++;
      $display("FAIL reset_credits: got %0d want 4", bus.o_credits);
    end
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, '0, 1'b0);
    tests++;
    if (obs() !== expv()) begin
      fails++;
      $display("FAIL reset_release: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_fill();
    int pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, W'(i), 1'b0);
      if (bus.o_v === 1'b1) pulses++;
      tests++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL fill_cycle%0d: got %h want %h", i, obs(), expv());
      end
    end
    tests++;
    if (pulses != 4 || bus.o_d !== 8'h04 || bus.i_r !== 1'b0 || bus.o_credits !== 3'd0) begin
      fails++;
      $display("FAIL fill_end: pulses %0d o_d %h i_r %b cred %0d want 4 04 0 0",
               pulses, bus.o_d, bus.i_r, bus.o_credits);
    end
  endtask

  task automatic test_credit_return();
    step(1'b1, 8'h05, 1'b1);
    tests++;
    if (obs() !== expv() || bus.i_r !== 1'b1 || bus.o_v !== 1'b0) begin
      fails++;
      $display("FAIL cr_reopen: got %h want %h", obs(), expv());
    end
    step(1'b1, 8'h05, 1'b0);
    tests++;
    if (obs() !== expv() || bus.o_v !== 1'b1 || bus.o_d !== 8'h05 || bus.o_credits !== 3'd0) begin
      fails++;
      $display("FAIL cr_send: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, '0, 1'b1);
    tests++;
    if (bus.o_credits !== 3'd1) begin
      fails++;
      $display("FAIL b2b_setup: got %0d want 1", bus.o_credits);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, W'($urandom), 1'b1);
      tests++;
      if (obs() !== expv() || bus.i_r !== 1'b1 || bus.o_v !== 1'b1 || bus.o_credits !== 3'd1) begin
        fails++;
        $display("FAIL b2b_cycle%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    tests++;
    if (obs() !== expv() || bus.o_idle !== 1'b1 || bus.o_err !== 1'b0) begin
      fails++;
      $display("FAIL ovf_idle: got %h want %h", obs(), expv());
    end
    step(1'b0, '0, 1'b1);
    tests++;
    if (obs() !== expv() || bus.o_err !== 1'b1 || bus.o_credits !== 3'd4) begin
      fails++;
      $display("FAIL ovf_set: got %h want %h", obs(), expv());
    end
    for (int i = 0; i < 8; i++) begin
      step(1'($urandom), W'($urandom), (i % 3) == 0);
      tests++;
      if (obs() !== expv() || bus.o_err !== 1'b1) begin
        fails++;
        $display("FAIL ovf_sticky%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    tests++;
    if (obs() !== expv() || bus.o_v !== 1'b1 || bus.o_credits !== 3'd2) begin
      fails++;
      $display("FAIL mid_setup: got %h want %h", obs(), expv());
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    tests++;
    if (obs() !== expv() || bus.o_v !== 1'b0 || bus.o_credits !== 3'd4) begin
      fails++;
      $display("FAIL mid_async: got %h want %h", obs(), expv());
    end
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'h3C, 1'b0);
    tests++;
    if (obs() !== expv() || bus.o_d !== 8'h3C || bus.o_credits !== 3'd3) begin
      fails++;
      $display("FAIL mid_resume: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit cr;
      cr = ($urandom_range(0, 99) < 45) && (m_cnt < CR);
      step(($urandom_range(0, 99) < 70), W'($urandom), cr);
      tests++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL random%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_credit_return();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
